uart_rx_ctrl: RTL and testbench

Register-mapped controller for the UART receiver datapath. It drives the receiver's enable, parity-type, bit-period and bit-period-write inputs, and consumes its valid/data/parity-error outputs. It buffers received bytes in a FIFO and tracks sticky errors. It also sequences safe baud reconfiguration by quiescing the receiver and waiting for line idle before re-enabling, and raises an interrupt to the core.

---
 rtl/uart_rx_ctrl_pkg.sv | 28 ++
 rtl/uart_rx_ctrl_if.sv | 19 +
 rtl/uart_rx_ctrl_fifo.sv | 51 +++++
 rtl/uart_rx_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: register map, field bit
// positions and the reconfiguration FSM state type.
package uart_rx_ctrl_pkg;

    localparam logic [3:0] AddrCtrl   = 4'h0;
    localparam logic [3:0] AddrBaud   = 4'h4;
    localparam logic [3:0] AddrStatus = 4'h8;
    localparam logic [3:0] AddrData   = 4'hC;

    localparam int unsigned CtrlEnBit     = 0;
    localparam int unsigned CtrlParityBit = 1;
    localparam int unsigned CtrlIrqEnBit  = 2;

    localparam int unsigned StatusEmptyBit   = 0;
    localparam int unsigned StatusFullBit    = 1;
    localparam int unsigned StatusOverrunBit = 2;
    localparam int unsigned StatusParityBit  = 3;
    localparam int unsigned StatusBusyBit    = 4;
    localparam int unsigned StatusTimeoutBit = 5;

    typedef enum logic [1:0] {
        StDisabled,
        StRun,
        StReconfLoad,
        StReconfGuard
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Register bus between the core (master) and the UART receive controller (slave).
interface uart_rx_ctrl_if;
    logic        bus_rd_i;
    logic        bus_wr_i;
    logic [3:0]  bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic [31:0] bus_rdata_o;
    logic        bus_ack_o;

    modport master (
        output bus_rd_i, bus_wr_i, bus_addr_i, bus_wdata_i,
        input  bus_rdata_o, bus_ack_o
    );

    modport slave (
        input  bus_rd_i, bus_wr_i, bus_addr_i, bus_wdata_i,
        output bus_rdata_o, bus_ack_o
    );
endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// rx_byte_fifo: synchronous byte FIFO; a push while full is accepted only when
// a pop happens in the same cycle.
module rx_byte_fifo #(
    parameter int unsigned Depth = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 wdata,
    output logic [7:0]                 rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);
    localparam int unsigned AW = $clog2(Depth);

    logic [7:0]    mem_q [Depth];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(Depth));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Register-mapped UART receive controller: RX FIFO, sticky errors, safe baud
// reconfiguration and interrupt. Optional idle timeout: UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned RX_THRESHOLD = 1,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_rx_ctrl_if.slave bus,
    input  logic        uart_rxd_i,
    output logic        rx_en_o,
    output logic        parity_type_o,
    output logic        wr_bit_period_o,
    output logic [15:0] bit_period_o,
    input  logic        rx_valid_i,
    input  logic        rx_parity_err_i,
    input  logic [7:0]  rx_data_i,
    output logic        irq_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [15:0] ResetPeriod = 16'(CLK_FREQ / BAUD_RATE - 1);

    rx_state_e     state_q, state_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          en_q, par_q, irq_en_q;
    logic [15:0]   bp_q;
    logic          overrun_q, perr_q, perr_in_q, load_pulse_q, ack_q, irq_q;
    logic [31:0]   rdata_q, rdata_d, status;
    logic          wr_en, rd_en, ctrl_wr, baud_wr, status_wr, data_rd;
    logic          push, pop, push_ok, full, empty, timeout, reconf_busy;
    logic [7:0]    head;
    logic [CW-1:0] count;

    // Write wins over a simultaneous read.
    assign wr_en     = bus.bus_wr_i;
    assign rd_en     = bus.bus_rd_i & ~bus.bus_wr_i;
    assign ctrl_wr   = wr_en & (bus.bus_addr_i == AddrCtrl);
    assign baud_wr   = wr_en & (bus.bus_addr_i == AddrBaud);
    assign status_wr = wr_en & (bus.bus_addr_i == AddrStatus);
    assign data_rd   = rd_en & (bus.bus_addr_i == AddrData);

    assign push    = rx_valid_i & (state_q == StRun);
    assign pop     = data_rd & ~empty;
    assign push_ok = push & (~full | pop);

    rx_byte_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (rx_data_i),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [23:0] idle_q, limit;
    logic        timeout_q, timeout_set;

    // Four character times of 10 bits each.
    assign limit       = (24'(bp_q) + 24'd1) * 24'd40;
    assign timeout_set = ~empty & ~push_ok & ~pop & (idle_q < limit) & (idle_q + 24'd1 >= limit);
    assign timeout     = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (push_ok || pop || empty) idle_q <= '0;
            else if (idle_q < limit)     idle_q <= idle_q + 24'd1;
            timeout_q <= timeout_set |
                         (timeout_q & ~(status_wr & bus.bus_wdata_i[StatusTimeoutBit]));
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        status                   = '0;
        status[StatusEmptyBit]   = empty;
        status[StatusFullBit]    = full;
        status[StatusOverrunBit] = overrun_q;
        status[StatusParityBit]  = perr_q;
        status[StatusBusyBit]    = reconf_busy;
        status[StatusTimeoutBit] = timeout;
        status[15:8]             = 8'(count);
    end

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (bus.bus_addr_i)
                AddrCtrl: begin
                    rdata_d[CtrlEnBit]     = en_q;
                    rdata_d[CtrlParityBit] = par_q;
                    rdata_d[CtrlIrqEnBit]  = irq_en_q;
                end
                AddrBaud:   rdata_d[15:0] = bp_q;
                AddrStatus: rdata_d       = status;
                AddrData:   rdata_d[7:0]  = empty ? 8'h00 : head;
                default:    rdata_d       = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            par_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            bp_q         <= ResetPeriod;
            overrun_q    <= 1'b0;
            perr_q       <= 1'b0;
            perr_in_q    <= 1'b0;
            load_pulse_q <= 1'b0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en_q     <= bus.bus_wdata_i[CtrlEnBit];
                par_q    <= bus.bus_wdata_i[CtrlParityBit];
                irq_en_q <= bus.bus_wdata_i[CtrlIrqEnBit];
            end
            if (baud_wr) bp_q <= bus.bus_wdata_i[15:0];
            // Set events take priority over a W1C in the same cycle.
            overrun_q <= (push & full & ~pop) |
                         (overrun_q & ~(status_wr & bus.bus_wdata_i[StatusOverrunBit]));
            perr_q    <= (rx_parity_err_i & ~perr_in_q) |
                         (perr_q & ~(status_wr & bus.bus_wdata_i[StatusParityBit]));
            perr_in_q    <= rx_parity_err_i;
            load_pulse_q <= baud_wr & (state_q == StDisabled);
            ack_q        <= bus.bus_rd_i | bus.bus_wr_i;
            rdata_q      <= rdata_d;
            irq_q        <= irq_en_q & ((count >= CW'(RX_THRESHOLD)) | overrun_q | perr_q |
                                        timeout);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StDisabled;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        guard_d = '0;
        unique case (state_q)
            StDisabled:   if (en_q) state_d = StRun;
            StRun: begin
                if (!en_q)        state_d = StDisabled;
                else if (baud_wr) state_d = StReconfLoad;
            end
            StReconfLoad: state_d = baud_wr ? StReconfLoad : StReconfGuard;
            StReconfGuard: begin
                if (baud_wr) begin
                    state_d = StReconfLoad;
                end else if (uart_rxd_i) begin
                    if (guard_q == GW'(GUARD_CYCLES - 1)) state_d = en_q ? StRun : StDisabled;
                    else                                  guard_d = guard_q + 1'b1;
                end
            end
            default:      state_d = StDisabled;
        endcase
    end

    always_comb begin
        rx_en_o         = (state_q == StRun);
        wr_bit_period_o = (state_q == StReconfLoad) | load_pulse_q;
        reconf_busy     = (state_q == StReconfLoad) | (state_q == StReconfGuard);
    end

    assign parity_type_o   = par_q;
    assign bit_period_o    = bp_q;
    assign irq_o           = irq_q;
    assign bus.bus_rdata_o = rdata_q;
    assign bus.bus_ack_o   = ack_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;
    import uart_rx_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rxd_i = 1'b1;
    logic        rx_en_o, parity_type_o, wr_bit_period_o, irq_o;
    logic [15:0] bit_period_o;
    logic        rx_valid_i = 1'b0;
    logic        rx_parity_err_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    int          checks = 0;
    int          errors = 0;

    uart_rx_ctrl_if bus_if ();

    uart_rx_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus_if),
        .uart_rxd_i      (uart_rxd_i),
        .rx_en_o         (rx_en_o),
        .parity_type_o   (parity_type_o),
        .wr_bit_period_o (wr_bit_period_o),
        .bit_period_o    (bit_period_o),
        .rx_valid_i      (rx_valid_i),
        .rx_parity_err_i (rx_parity_err_i),
        .rx_data_i       (rx_data_i),
        .irq_o           (irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.bus_wr_i = 1'b1;
        bus_if.bus_addr_i = a;
        bus_if.bus_wdata_i = d;
        @(negedge clk);
        bus_if.bus_wr_i = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.bus_rd_i = 1'b1;
        bus_if.bus_addr_i = a;
        @(negedge clk);
        bus_if.bus_rd_i = 1'b0;
        d = bus_if.bus_rdata_o;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clk);
        rx_valid_i = 1'b1;
        rx_data_i = b;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        bus_if.bus_rd_i = 1'b0;
        bus_if.bus_wr_i = 1'b0;
        bus_if.bus_addr_i = '0;
        bus_if.bus_wdata_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bit_period_o !== 16'd433) begin
            errors++; $display("FAIL reset_bit_period: got %0d expected 433", bit_period_o);
        end
        checks++;
        if ({rx_en_o, wr_bit_period_o, parity_type_o, irq_o, bus_if.bus_ack_o} !== 5'b0 ||
            bus_if.bus_rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: en=%b wr=%b par=%b irq=%b ack=%b rdata=%h expected all 0",
                               rx_en_o, wr_bit_period_o, parity_type_o, irq_o, bus_if.bus_ack_o,
                               bus_if.bus_rdata_o);
        end
        bus_read(AddrBaud, r);
        checks++;
        if (r !== 32'h1B1) begin
            errors++; $display("FAIL reset_baud_read: got %h expected 000001b1", r);
        end
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h1) begin
            errors++; $display("FAIL reset_status: got %h expected 00000001", r);
        end
    endtask

    task automatic test_bus();
        logic [31:0] r;
        bus_write(AddrCtrl, 32'h5);
        bus_read(AddrCtrl, r);
        checks++;
        if (r !== 32'h5 || bus_if.bus_ack_o !== 1'b1) begin
            errors++; $display("FAIL ctrl_read: got %h ack %b expected 00000005 ack 1", r, bus_if.bus_ack_o);
        end
        bus_read(4'h2, r);
        checks++;
        if (r !== 32'h0) begin
            errors++; $display("FAIL unmapped_read: got %h expected 0", r);
        end
        @(negedge clk);
        bus_if.bus_rd_i = 1'b1;
        bus_if.bus_wr_i = 1'b1;
        bus_if.bus_addr_i = AddrCtrl;
        bus_if.bus_wdata_i = 32'h5;
        @(negedge clk);
        bus_if.bus_rd_i = 1'b0;
        bus_if.bus_wr_i = 1'b0;
        checks++;
        if (bus_if.bus_rdata_o !== 32'h0 || bus_if.bus_ack_o !== 1'b1) begin
            errors++; $display("FAIL rd_wr_collision: rdata %h ack %b expected 0 ack 1",
                               bus_if.bus_rdata_o, bus_if.bus_ack_o);
        end
        @(negedge clk);
        checks++;
        if (rx_en_o !== 1'b1) begin
            errors++; $display("FAIL enable_run: rx_en %b expected 1", rx_en_o);
        end
    endtask

    task automatic test_data();
        logic [31:0] r;
        logic [31:0] exp_rd [4] = '{32'h41, 32'h42, 32'h43, 32'h0};
        rx_push(8'h41);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++; $display("FAIL irq_latency_early: got %b expected 0", irq_o);
        end
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++; $display("FAIL irq_after_push: got %b expected 1", irq_o);
        end
        rx_push(8'h42);
        rx_push(8'h43);
        for (int i = 0; i < 4; i++) begin
            bus_read(AddrData, r);
            checks++;
            if (r !== exp_rd[i]) begin
                errors++; $display("FAIL data_read_%0d: got %h expected %h", i, r, exp_rd[i]);
            end
        end
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h1) begin
            errors++; $display("FAIL status_after_drain: got %h expected 00000001", r);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        logic [31:0] e;
        for (int i = 0; i < 16; i++) rx_push(8'h10 + 8'(i));
        rx_push(8'hEE);
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h1006) begin
            errors++; $display("FAIL status_full_overrun: got %h expected 00001006", r);
        end
        bus_write(AddrStatus, 32'h4);
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h1002) begin
            errors++; $display("FAIL overrun_clear: got %h expected 00001002", r);
        end
        @(negedge clk);
        rx_valid_i = 1'b1;
        rx_data_i = 8'h55;
        bus_if.bus_rd_i = 1'b1;
        bus_if.bus_addr_i = AddrData;
        @(negedge clk);
        rx_valid_i = 1'b0;
        bus_if.bus_rd_i = 1'b0;
        checks++;
        if (bus_if.bus_rdata_o !== 32'h10) begin
            errors++; $display("FAIL push_pop_full_data: got %h expected 00000010", bus_if.bus_rdata_o);
        end
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h1002) begin
            errors++; $display("FAIL push_pop_full_status: got %h expected 00001002", r);
        end
        for (int i = 0; i < 16; i++) begin
            e = (i < 15) ? 32'h11 + 32'(i) : 32'h55;
            bus_read(AddrData, r);
            checks++;
            if (r !== e) begin
                errors++; $display("FAIL wrap_drain_%0d: got %h expected %h", i, r, e);
            end
        end
    endtask

    task automatic test_reconfig();
        logic [31:0] r;
        int pulses = 0;
        int n = 0;
        logic en_seen = 1'b0;
        uart_rxd_i = 1'b0;
        bus_write(AddrBaud, 32'hABCD0033);
        for (int i = 0; i < 20; i++) begin
            if (wr_bit_period_o) pulses++;
            if (rx_en_o) en_seen = 1'b1;
            @(negedge clk);
        end
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h11) begin
            errors++; $display("FAIL reconf_busy_status: got %h expected 00000011", r);
        end
        if (rx_en_o) en_seen = 1'b1;
        uart_rxd_i = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (wr_bit_period_o) pulses++;
            if (rx_en_o) break;
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL wr_bit_period_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (en_seen !== 1'b0) begin
            errors++; $display("FAIL rx_en_during_low: got %b expected 0", en_seen);
        end
        checks++;
        if (n != 16 || rx_en_o !== 1'b1) begin
            errors++; $display("FAIL guard_high_cycles: got %0d (rx_en %b) expected 16 (rx_en 1)",
                               n, rx_en_o);
        end
        bus_read(AddrBaud, r);
        checks++;
        if (r !== 32'h33 || bit_period_o !== 16'h33) begin
            errors++; $display("FAIL baud_after_reconf: got %h / %h expected 00000033 / 0033",
                               r, bit_period_o);
        end
    endtask

    task automatic test_parity();
        logic [31:0] r;
        @(negedge clk);
        rx_parity_err_i = 1'b1;
        repeat (3) @(negedge clk);
        rx_parity_err_i = 1'b0;
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h9) begin
            errors++; $display("FAIL parity_status: got %h expected 00000009", r);
        end
        checks++;
        if (irq_o !== 1'b1) begin
            errors++; $display("FAIL parity_irq: got %b expected 1", irq_o);
        end
        bus_write(AddrStatus, 32'h8);
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h1) begin
            errors++; $display("FAIL parity_clear: got %h expected 00000001", r);
        end
        // Held level must not re-set the flag once cleared.
        @(negedge clk);
        rx_parity_err_i = 1'b1;
        repeat (2) @(negedge clk);
        bus_write(AddrStatus, 32'h8);
        bus_read(AddrStatus, r);
        rx_parity_err_i = 1'b0;
        checks++;
        if (r !== 32'h1) begin
            errors++; $display("FAIL parity_edge_only: got %h expected 00000001", r);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++; $display("FAIL irq_idle: got %b expected 0", irq_o);
        end
    endtask

    task automatic test_disabled_baud();
        logic [31:0] r;
        rx_push(8'h77);
        bus_write(AddrCtrl, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (rx_en_o !== 1'b0) begin
            errors++; $display("FAIL disable_rx_en: got %b expected 0", rx_en_o);
        end
        bus_write(AddrBaud, 32'h0100);
        checks++;
        if (wr_bit_period_o !== 1'b1 || bit_period_o !== 16'h0100) begin
            errors++; $display("FAIL disabled_baud_pulse: wr %b period %h expected 1 0100",
                               wr_bit_period_o, bit_period_o);
        end
        @(negedge clk);
        checks++;
        if (wr_bit_period_o !== 1'b0 || rx_en_o !== 1'b0) begin
            errors++; $display("FAIL disabled_baud_single: wr %b en %b expected 0 0",
                               wr_bit_period_o, rx_en_o);
        end
        rx_push(8'h99);
        bus_read(AddrStatus, r);
        checks++;
        if (r !== 32'h100) begin
            errors++; $display("FAIL no_flush_status: got %h expected 00000100", r);
        end
        bus_read(AddrData, r);
        checks++;
        if (r !== 32'h77) begin
            errors++; $display("FAIL no_flush_data: got %h expected 00000077", r);
        end
    endtask

`ifdef UART_RX_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] r;
        uart_rxd_i = 1'b1;
        bus_write(AddrCtrl, 32'h5);
        repeat (2) @(negedge clk);
        bus_write(AddrBaud, 32'h9);
        repeat (30) @(negedge clk);
        rx_push(8'h5A);
        repeat (400) @(negedge clk);
        bus_read(AddrStatus, r);
        checks++;
        if (r[5] !== 1'b1 || irq_o !== 1'b1) begin
            errors++; $display("FAIL timeout_flag: status %h irq %b expected bit5 1 irq 1", r, irq_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bus();
        test_data();
        test_overrun();
        test_reconfig();
        test_parity();
        test_disabled_baud();
`ifdef UART_RX_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
